writeback_scheduler: RTL and testbench
======================================

# writeback_scheduler

Owns the single write port of the integer register file and the pending-destination scoreboard around it. Two writeback requesters, the execute stage and the memory/load unit, compete for the one write port under round-robin arbitration with a valid/ready handshake. The block drives the register file write controls from registers and tracks which architectural registers have an issued but not yet written result. Issue logic uses the stall output to hold RAW and WAW hazards.

## Interface
- No parameters (32 registers × 32 bits fixed; x0 hardwired zero).
- i_Clock  in  1  sole clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_IssueValid  in  1  instruction with destination leaves issue this cycle
- i_IssueRegDest  in  5  its destination register
- i_CheckRs1 / i_CheckRs2 / i_CheckRd  in  5 each  operands/destination of instruction waiting at issue
- o_Stall  out  1  combinational hazard flag for the checked instruction
- i_ExValid / o_ExReady  in/out  1 each  execute-stage writeback handshake
- i_ExRegDest / i_ExData  in  5/32  execute result
- i_MemValid / o_MemReady  in/out  1 each  memory-unit writeback handshake
- i_MemRegDest / i_MemData  in  5/32  load result
- o_WriteEnable / o_RegDest / o_DataIn  out  1/5/32  to register file write port, registered
- o_Pending  out  32  scoreboard vector, bit 0 always 0
- o_Error  out  1  sticky protocol-violation flag

## Operation
- Arbitration: round-robin over {Ex, Mem}, pointer r_LastGrant (0 = Ex, 1 = Mem).
  - One valid → it is granted.
  - Both valid → grant the requester not in r_LastGrant.
  - r_LastGrant updates only on a grant.
- o_ExReady / o_MemReady are combinational grant signals.
  - Transfer occurs when valid && ready on a rising edge.
  - Requesters hold valid, dest and data stable until transfer.
  - Ready never asserts without its valid.
- Write port register: on a transfer, the next cycle shows o_WriteEnable = 1 with the granted dest/data. Otherwise o_WriteEnable = 0; o_RegDest and o_DataIn hold their last values.
- Dest 0: the handshake completes, o_WriteEnable stays 0, nothing is written.
- Scoreboard r_Pending[31:1]:
  - Set bit IssueRegDest on i_IssueValid when IssueRegDest ≠ 0.
  - Clear bit o_RegDest at the edge where o_WriteEnable = 1, which is the edge the register file commits.
  - Set and clear of the same bit on the same edge: set wins.
- o_Stall = pending-with-bypass(rs1) | pending-with-bypass(rs2) | pending(rd).
  - pending-with-bypass(r) = r_Pending[r] && !(o_WriteEnable && o_RegDest == r). The register file forwards same-edge writes to its read ports.
  - rd is checked without bypass, so a WAW is held until the clear has taken effect.
  - Checks of x0 never stall.
- o_Error sets and holds until reset on any of:
  - i_IssueValid to an already-pending nonzero register (unless cleared that edge);
  - a writeback transfer to a nonzero register whose pending bit is 0;
  - valid deasserted without a transfer.

## Timing
- Reset (async, immediate): o_WriteEnable = 0, o_RegDest = 0, o_DataIn = 0, o_Pending = 0, o_Error = 0, r_LastGrant = 1 (Ex wins first contention).
- Ready outputs follow valid within reset: both 0 while i_Reset is high.
- Latency:
  - Transfer edge → o_WriteEnable visible 1 cycle later.
  - Register file commits at the following edge.
  - Pending bit clears at that same commit edge.
- Throughput: one writeback per cycle sustained. With both requesters continuously valid, grants alternate Ex, Mem, Ex, ...
- Issue → pending visible the cycle after i_IssueValid. The issuing instruction's own dependents see o_Stall the next cycle.
- Reset mid-operation discards in-flight handshakes and the pending state. Upstream flushes accordingly.

## Test plan
- Reset, then i_ExValid with dest 5, data 0xDEADBEEF → o_ExReady = 1 same cycle; next cycle o_WriteEnable = 1, o_RegDest = 5, o_DataIn = 0xDEADBEEF; following cycle o_WriteEnable = 0.
- Ex and Mem both valid for 4 cycles (dests 1 and 2) → grants Ex, Mem, Ex, Mem; neither ready held low for 2 consecutive cycles.
- Issue dest 7; check rs1 = 7 → o_Stall = 1 until o_WriteEnable with dest 7. During that cycle o_Stall = 0 via bypass, but o_Stall = 1 if rd = 7. o_Pending[7] is 0 afterwards.
- Issue dest 9 on the same edge that writeback of 9 commits → o_Pending[9] stays 1, o_Error stays 0.
- Writeback to dest 0 with data 0xFFFFFFFF → handshake completes, o_WriteEnable stays 0; checks of x0 never stall.
- Violations: issue to a pending register, writeback to a non-pending register 3, or valid dropped before ready → o_Error = 1 and held until i_Reset; asserting i_Reset mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/writeback_scheduler_if.sv
// Writeback handshake bundle between the two result producers (execute, memory)
// and the register-file write scheduler.
interface writeback_scheduler_if;
  logic        i_ExValid;
  logic        o_ExReady;
  logic [4:0]  i_ExRegDest;
  logic [31:0] i_ExData;

  logic        i_MemValid;
  logic        o_MemReady;
  logic [4:0]  i_MemRegDest;
  logic [31:0] i_MemData;

  // Producers drive valid/dest/data and watch ready.
  modport master (
    output i_ExValid, i_ExRegDest, i_ExData,
    output i_MemValid, i_MemRegDest, i_MemData,
    input  o_ExReady, o_MemReady
  );

  modport slave (
    input  i_ExValid, i_ExRegDest, i_ExData,
    input  i_MemValid, i_MemRegDest, i_MemData,
    output o_ExReady, o_MemReady
  );
endinterface

// File: rtl/writeback_scheduler.sv
// Round-robin owner of the integer register file write port, plus the
// pending-destination scoreboard that issue logic consults for RAW/WAW stalls.
module writeback_scheduler (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  writeback_scheduler_if.slave  wbPort,
  input  logic                  i_IssueValid,
  input  logic [4:0]            i_IssueRegDest,
  input  logic [4:0]            i_CheckRs1,
  input  logic [4:0]            i_CheckRs2,
  input  logic [4:0]            i_CheckRd,
  output logic                  o_Stall,
  output logic                  o_WriteEnable,
  output logic [4:0]            o_RegDest,
  output logic [31:0]           o_DataIn,
  output logic [31:0]           o_Pending,
  output logic                  o_Error
);

  typedef enum logic {
    GRANT_EX  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e      r_LastGrant;
  logic [31:0] r_Pending;
  logic        r_ExWaiting;
  logic        r_MemWaiting;

  logic        exGrant;
  logic        memGrant;
  logic        anyGrant;
  logic [4:0]  grantDest;
  logic [31:0] grantData;
  logic        writeNext;

  logic [31:0] clearMask;
  logic [31:0] setMask;
  logic [31:0] pendingNext;
  logic        issueConflict;
  logic        orphanWrite;
  logic        droppedValid;

  function automatic logic isPending(input logic [31:0] pend, input logic [4:0] r);
    return (r != 5'd0) && pend[r];
  endfunction

  // Grant is combinational; held low during reset so no handshake can complete.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    exGrant  = 1'b0;
    memGrant = 1'b0;
    if (!i_Reset) begin
      exGrant  = wbPort.i_ExValid  && (!wbPort.i_MemValid || r_LastGrant == GRANT_MEM);
      memGrant = wbPort.i_MemValid && (!wbPort.i_ExValid  || r_LastGrant == GRANT_EX);
    end
    anyGrant  = exGrant || memGrant;
    grantDest = exGrant ? wbPort.i_ExRegDest : wbPort.i_MemRegDest;
    grantData = exGrant ? wbPort.i_ExData    : wbPort.i_MemData;
    writeNext = anyGrant && (grantDest != 5'd0);
  end

  assign wbPort.o_ExReady  = exGrant;
  assign wbPort.o_MemReady = memGrant;

  // The bit being committed this edge clears; a same-edge issue re-sets it.
  always_comb begin
    clearMask = '0;
    setMask   = '0;
    if (o_WriteEnable) clearMask[o_RegDest] = 1'b1;
    if (i_IssueValid && i_IssueRegDest != 5'd0) setMask[i_IssueRegDest] = 1'b1;
    pendingNext    = (r_Pending & ~clearMask) | setMask;
    pendingNext[0] = 1'b0;

    issueConflict = |(r_Pending & ~clearMask & setMask);
    orphanWrite   = writeNext && !r_Pending[grantDest];
    droppedValid  = (r_ExWaiting && !wbPort.i_ExValid) ||
                    (r_MemWaiting && !wbPort.i_MemValid);
  end

  // Sources use the same-edge register-file bypass; the destination does not.
  assign o_Stall =
      (isPending(r_Pending, i_CheckRs1) && !(o_WriteEnable && o_RegDest == i_CheckRs1)) ||
      (isPending(r_Pending, i_CheckRs2) && !(o_WriteEnable && o_RegDest == i_CheckRs2)) ||
       isPending(r_Pending, i_CheckRd);

  assign o_Pending = r_Pending;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_LastGrant   <= GRANT_MEM;
      r_Pending     <= '0;
      r_ExWaiting   <= 1'b0;
      r_MemWaiting  <= 1'b0;
      o_WriteEnable <= 1'b0;
      o_RegDest     <= '0;
      o_DataIn      <= '0;
      o_Error       <= 1'b0;
    end else begin
      r_Pending     <= pendingNext;
      o_WriteEnable <= writeNext;
      if (writeNext) begin
        o_RegDest <= grantDest;
        o_DataIn  <= grantData;
      end
      if (exGrant)       r_LastGrant <= GRANT_EX;
      else if (memGrant) r_LastGrant <= GRANT_MEM;
      r_ExWaiting  <= wbPort.i_ExValid  && !exGrant;
      r_MemWaiting <= wbPort.i_MemValid && !memGrant;
      o_Error      <= o_Error || issueConflict || orphanWrite || droppedValid;
    end
  end

endmodule

// File: tb/tb_writeback_scheduler.sv
// Directed and randomized bench for writeback_scheduler against a cycle-level
// reference model built from arrays of pending flags and a last-served pointer.
module tb_writeback_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issueValid = 1'b0;
  logic [4:0]  issueRegDest = '0;
  logic [4:0]  checkRs1 = '0;
  logic [4:0]  checkRs2 = '0;
  logic [4:0]  checkRd = '0;
  logic        stall;
  logic        writeEnable;
  logic [4:0]  regDest;
  logic [31:0] dataIn;
  logic [31:0] pending;
  logic        error;

  writeback_scheduler_if wbIf ();

  writeback_scheduler dut (
    .i_Clock        (clock),
    .i_Reset        (reset),
    .wbPort         (wbIf),
    .i_IssueValid   (issueValid),
    .i_IssueRegDest (issueRegDest),
    .i_CheckRs1     (checkRs1),
    .i_CheckRs2     (checkRs2),
    .i_CheckRd      (checkRd),
    .o_Stall        (stall),
    .o_WriteEnable  (writeEnable),
    .o_RegDest      (regDest),
    .o_DataIn       (dataIn),
    .o_Pending      (pending),
    .o_Error        (error)
  );

  always #5 clock = ~clock;

  int compCount = 0;
  int failCount = 0;

  // Reference model state.
  bit          mPend[32];
  bit          mLastMem;
  bit          mWe;
  logic [4:0]  mDest;
  logic [31:0] mData;
  bit          mErr;
  bit          mExWait, mMemWait;
  bit          lastExGrant, lastMemGrant;
  bit          owned[32];
  bit          exBusy, memBusy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit expExGrant();
    return wbIf.i_ExValid && (!wbIf.i_MemValid || mLastMem);
  endfunction

  function automatic bit expMemGrant();
    return wbIf.i_MemValid && (!wbIf.i_ExValid || !mLastMem);
  endfunction

  function automatic bit hazard(input logic [4:0] r, input bit bypass);
    if (r == 5'd0) return 1'b0;
    return mPend[r] && !(bypass && mWe && mDest == r);
  endfunction

  function automatic logic [31:0] pendVec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mPend[i];
    return v;
  endfunction

  task automatic checkAll();
    check("exReady", wbIf.o_ExReady, expExGrant());
    check("memReady", wbIf.o_MemReady, expMemGrant());
    check("stall", stall, hazard(checkRs1, 1) | hazard(checkRs2, 1) | hazard(checkRd, 0));
    check("writeEnable", writeEnable, mWe);
    if (mWe) begin
      check("regDest", regDest, mDest);
      check("dataIn", dataIn, mData);
    end
    check("pending", pending, pendVec());
    check("error", error, mErr);
  endtask

  task automatic modelEdge();
    bit eg, mg;
    logic [4:0] gd;
    logic [31:0] gdata;
    int clr;
    eg  = expExGrant();
    mg  = expMemGrant();
    gd  = eg ? wbIf.i_ExRegDest : wbIf.i_MemRegDest;
    gdata = eg ? wbIf.i_ExData : wbIf.i_MemData;
    clr = mWe ? int'(mDest) : 0;
    if (issueValid && issueRegDest != 0 && mPend[issueRegDest] && clr != int'(issueRegDest)) mErr = 1;
    if ((eg || mg) && gd != 0 && !mPend[gd]) mErr = 1;
    if (mExWait && !wbIf.i_ExValid) mErr = 1;
    if (mMemWait && !wbIf.i_MemValid) mErr = 1;
    if (clr != 0) begin
      mPend[clr] = 0;
      owned[clr] = 0;
    end
    if (issueValid && issueRegDest != 0) mPend[issueRegDest] = 1;
    mWe = (eg || mg) && gd != 0;
    if (mWe) begin
      mDest = gd;
      mData = gdata;
    end
    if (eg) mLastMem = 0;
    else if (mg) mLastMem = 1;
    mExWait  = wbIf.i_ExValid && !eg;
    mMemWait = wbIf.i_MemValid && !mg;
    lastExGrant  = eg;
    lastMemGrant = mg;
  endtask

  task automatic tick();
    @(negedge clock);
    checkAll();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic setEx(input bit v, input logic [4:0] d, input logic [31:0] x);
    wbIf.i_ExValid = v; wbIf.i_ExRegDest = d; wbIf.i_ExData = x;
  endtask

  task automatic setMem(input bit v, input logic [4:0] d, input logic [31:0] x);
    wbIf.i_MemValid = v; wbIf.i_MemRegDest = d; wbIf.i_MemData = x;
  endtask

  task automatic issue(input bit v, input logic [4:0] d);
    issueValid = v; issueRegDest = d;
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, " writeEnable"}, writeEnable, 0);
    check({tag, " regDest"}, regDest, 0);
    check({tag, " dataIn"}, dataIn, 0);
    check({tag, " pending"}, pending, 0);
    check({tag, " error"}, error, 0);
    check({tag, " exReady"}, wbIf.o_ExReady, 0);
    check({tag, " memReady"}, wbIf.o_MemReady, 0);
    for (int i = 0; i < 32; i++) begin
      mPend[i] = 0;
      owned[i] = 0;
    end
    mLastMem = 1; mWe = 0; mDest = '0; mData = '0; mErr = 0;
    mExWait = 0; mMemWait = 0; exBusy = 0; memBusy = 0;
    setEx(0, 0, 0); setMem(0, 0, 0); issue(0, 0);
    checkRs1 = 0; checkRs2 = 0; checkRd = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic int findPending();
    int start = $urandom_range(1, 31);
    for (int k = 0; k < 31; k++) begin
      int r = 1 + ((start - 1 + k) % 31);
      if (mPend[r] && !owned[r]) return r;
    end
    return -1;
  endfunction

  // Legal producer: presents either x0 or a pending, not-yet-claimed register.
  task automatic pickRequest(output bit v, output logic [4:0] d);
    int r;
    v = 0; d = 0;
    if ($urandom_range(0, 2) == 0) return;
    if ($urandom_range(0, 7) == 0) begin
      v = 1;
      return;
    end
    r = findPending();
    if (r > 0) begin
      v = 1;
      d = 5'(r);
      owned[r] = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v;
    logic [4:0] d;
    int r;
    setEx(0, 0, 0); setMem(0, 0, 0);
    #1;
    doReset("reset");

    // Single execute writeback.
    issue(1, 5); tick(); issue(0, 0);
    setEx(1, 5, 32'hDEADBEEF);
    #1 check("t1 exReady", wbIf.o_ExReady, 1);
    tick(); setEx(0, 0, 0);
    #1;
    check("t1 we", writeEnable, 1);
    check("t1 dest", regDest, 5);
    check("t1 data", dataIn, 32'hDEADBEEF);
    check("t1 pend5 held", pending[5], 1);
    tick();
    #1;
    check("t1 we drop", writeEnable, 0);
    check("t1 pend5 clear", pending[5], 0);
    tick();

    // Contention alternates starting with execute after reset.
    doReset("reset2");
    for (int i = 1; i <= 5; i++) begin
      issue(1, 5'(i)); tick();
    end
    issue(0, 0);
    setEx(1, 1, 32'hA1); setMem(1, 2, 32'hB2);
    #1 check("arb c0 ex", wbIf.o_ExReady, 1); check("arb c0 mem", wbIf.o_MemReady, 0);
    tick(); setEx(1, 3, 32'hA3);
    #1 check("arb c1 ex", wbIf.o_ExReady, 0); check("arb c1 mem", wbIf.o_MemReady, 1);
    tick(); setMem(1, 4, 32'hB4);
    #1 check("arb c2 ex", wbIf.o_ExReady, 1); check("arb c2 mem", wbIf.o_MemReady, 0);
    tick(); setEx(1, 5, 32'hA5);
    #1 check("arb c3 ex", wbIf.o_ExReady, 0); check("arb c3 mem", wbIf.o_MemReady, 1);
    tick(); setMem(0, 0, 0);
    tick(); setEx(0, 0, 0);
    tick(); tick();
    #1 check("arb pending drained", pending, 0); check("arb error", error, 0);

    // RAW bypass versus WAW hold.
    issue(1, 7); checkRs1 = 7; tick(); issue(0, 0);
    #1 check("haz stall pending", stall, 1);
    tick();
    #1 check("haz stall held", stall, 1);
    setEx(1, 7, 32'h77); tick(); setEx(0, 0, 0);
    #1 check("haz we7", writeEnable, 1); check("haz bypass", stall, 0);
    checkRd = 7;
    #1 check("haz waw", stall, 1);
    checkRd = 0;
    tick();
    #1 check("haz pend7 clear", pending[7], 0); check("haz no stall", stall, 0);
    checkRs1 = 0;

    // Reissue on the commit edge: set wins, no error.
    issue(1, 9); tick(); issue(0, 0);
    setEx(1, 9, 32'h99); tick(); setEx(0, 0, 0);
    issue(1, 9); tick(); issue(0, 0);
    #1 check("reissue pend9", pending[9], 1); check("reissue error", error, 0);
    setMem(1, 9, 32'h999); tick(); setMem(0, 0, 0); tick(); tick();

    // Writeback to x0 and x0 checks.
    setMem(1, 0, 32'hFFFFFFFF);
    #1 check("x0 memReady", wbIf.o_MemReady, 1);
    tick(); setMem(0, 0, 0); issue(1, 0);
    #1 check("x0 no write", writeEnable, 0);
    tick(); issue(0, 0);
    #1 check("x0 pending0", pending[0], 0); check("x0 stall", stall, 0);

    // Randomized legal traffic.
    for (int c = 0; c < 800; c++) begin
      if (lastExGrant) begin exBusy = 0; setEx(0, 0, 0); end
      if (lastMemGrant) begin memBusy = 0; setMem(0, 0, 0); end
      r = $urandom_range(1, 31);
      if ($urandom_range(0, 1) == 1 && !mPend[r] && !owned[r]) issue(1, 5'(r));
      else issue(0, 0);
      if (!exBusy) begin
        pickRequest(v, d);
        setEx(v, d, $urandom);
        exBusy = v;
      end
      if (!memBusy) begin
        pickRequest(v, d);
        setMem(v, d, $urandom);
        memBusy = v;
      end
      checkRs1 = 5'($urandom_range(0, 31));
      checkRs2 = 5'($urandom_range(0, 31));
      checkRd  = 5'($urandom_range(0, 31));
      tick();
    end
    issue(0, 0);
    #1 check("random error", error, 0);

    // Violation: issue to an already-pending register.
    doReset("reset3");
    issue(1, 3); tick(); issue(1, 3); tick(); issue(0, 0);
    #1 check("viol issue", error, 1);
    tick(); tick();
    #1 check("viol issue sticky", error, 1);

    // Violation: writeback to a non-pending register.
    doReset("reset4");
    setEx(1, 3, 32'h33);
    #1 check("viol orphan ready", wbIf.o_ExReady, 1);
    tick(); setEx(0, 0, 0);
    #1 check("viol orphan", error, 1);
    tick();

    // Violation: valid withdrawn before ready.
    doReset("reset5");
    issue(1, 4); tick(); issue(1, 6); tick(); issue(0, 0);
    setEx(1, 4, 32'h44); setMem(1, 6, 32'h66);
    tick(); setEx(0, 0, 0); setMem(0, 0, 0);
    tick();
    #1 check("viol dropped", error, 1);

    // Reset mid-stream with a write pending and requesters valid.
    issue(1, 8); tick(); issue(0, 0);
    setEx(1, 8, 32'h88); tick(); setEx(0, 0, 0);
    setMem(1, 0, 32'h5);
    doReset("midreset");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
